// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: access size codes and bus FSM states.
package mem_access_stage_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_stage_lane_align.sv
// Combinational lane steering: byte enables, store replication, load extract/extend,
// and the alignment check for the current access size.
module mem_lane_align
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]          size,
    input  logic                uns,
    input  logic [2:0]          addr_lo,
    input  logic [DATA_W-1:0]   st_data,
    input  logic [DATA_W-1:0]   rdata,
    output logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   ld_data,
    output logic                aligned
);

    localparam int NB   = DATA_W / 8;
    localparam int OFFW = $clog2(NB);

    logic [OFFW-1:0]   off;
    logic [DATA_W-1:0] lane;

    assign off  = addr_lo[OFFW-1:0];
    assign lane = rdata >> {off, 3'b000};

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input int unsigned bits,
                                                 input logic zx);
        logic [DATA_W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < DATA_W; i++)
            if (i >= bits) r[i] = zx ? 1'b0 : v[bits-1];
        return r;
    endfunction

    always_comb begin
        be      = '0;
        wdata   = '0;
        ld_data = '0;
        aligned = 1'b1;
        case (mem_size_e'(size))
            SZ_B: begin
                be      = NB'(1) << off;
                wdata   = {NB{st_data[7:0]}};
                ld_data = extend(lane, 8, uns);
            end
            SZ_H: begin
                aligned = ~addr_lo[0];
                be      = NB'(3) << off;
                wdata   = {(NB/2){st_data[15:0]}};
                ld_data = extend(lane, 16, uns);
            end
            SZ_W: begin
                aligned = (addr_lo[1:0] == 2'b00);
                be      = NB'(15) << off;
                wdata   = {(NB/4){st_data[31:0]}};
                ld_data = extend(lane, 32, uns);
            end
            default: begin
                // Doubleword only exists on a 64-bit datapath.
                aligned = (DATA_W == 64) && (addr_lo == 3'b000);
                be      = '1;
                wdata   = st_data;
                ld_data = lane;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack FSM with optional ack timeout, and the MEM/WB register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_AW      = 5,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic [1:0]          mem_size,
    input  logic                mem_uns,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   st_data,
    input  logic                rwe_i,
    input  logic [REG_AW-1:0]   rwa_i,
    input  logic [DATA_W-1:0]   rwd_i,
    output logic                stall_o,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [DATA_W/8-1:0] dmem_be,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_ack,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic                wb_valid,
    output logic                wb_we,
    output logic [REG_AW-1:0]   wb_wa,
    output logic [DATA_W-1:0]   wb_wd,
    output logic                misalign_o,
    output logic                buserr_o
);

    localparam int NB   = DATA_W / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(ACK_TIMEOUT + 1) + 1;
    localparam int TLIM = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

    mem_state_e        state;
    logic [CW-1:0]     tcnt;
    logic              aligned, is_mem, mem_op, busy, ack_hit, timeout_hit, is_load;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata, ld_data;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size    (mem_size),
        .uns     (mem_uns),
        .addr_lo (mem_addr[2:0]),
        .st_data (st_data),
        .rdata   (dmem_rdata),
        .be      (be),
        .wdata   (wdata),
        .ld_data (ld_data),
        .aligned (aligned)
    );

    assign is_mem  = in_valid & (mem_rd | mem_wr);
    assign mem_op  = is_mem & aligned;
    assign is_load = mem_rd & ~mem_wr;
    assign busy    = (state == ST_BUSY);
    assign ack_hit = busy & dmem_ack;
    // The Nth BUSY cycle without ack is the timeout cycle; ack in that cycle still wins.
    assign timeout_hit = (ACK_TIMEOUT != 0) && busy && !dmem_ack && (tcnt == CW'(TLIM));
    assign stall_o     = mem_op & ~ack_hit & ~timeout_hit;

    assign dmem_req   = busy;
    assign dmem_we    = busy & mem_wr;
    assign dmem_addr  = busy ? {mem_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}} : '0;
    assign dmem_be    = busy ? be : '0;
    assign dmem_wdata = (busy & mem_wr) ? wdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tcnt       <= '0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_wa      <= '0;
            wb_wd      <= '0;
            misalign_o <= 1'b0;
            buserr_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (mem_op) state <= ST_BUSY;
                default: if (dmem_ack || timeout_hit) state <= ST_IDLE;
            endcase
            tcnt       <= (busy && !dmem_ack && !timeout_hit) ? tcnt + CW'(1) : '0;
            misalign_o <= is_mem & ~aligned;
            buserr_o   <= timeout_hit;
            wb_wa      <= rwa_i;
            wb_wd      <= rwd_i;
            if (is_mem && !aligned) begin
                wb_valid <= 1'b1;
                wb_we    <= 1'b0;
            end else if (!is_mem) begin
                wb_valid <= in_valid;
                wb_we    <= in_valid & rwe_i;
            end else if (ack_hit) begin
                wb_valid <= 1'b1;
                wb_we    <= rwe_i;
                if (is_load) wb_wd <= ld_data;
            end else if (timeout_hit) begin
                wb_valid <= 1'b1;
                wb_we    <= 1'b0;
            end else begin
                wb_valid <= 1'b0;
                wb_we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with an instruction-level reference model
// plus directed cases with literal expectations.
module tb_mem_access_stage;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, mem_rd, mem_wr, mem_uns, rwe_i;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] st_data, rwd_i;
    logic [RW-1:0] rwa_i;
    logic          stall_o, dmem_req, dmem_we, dmem_ack;
    logic [AW-1:0] dmem_addr;
    logic [3:0]    dmem_be;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic          wb_valid, wb_we, misalign_o, buserr_o;
    logic [RW-1:0] wb_wa;
    logic [DW-1:0] wb_wd;

    mem_access_stage #(.DATA_W(DW), .ADDR_W(AW), .REG_AW(RW), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_size(mem_size), .mem_uns(mem_uns), .mem_addr(mem_addr), .st_data(st_data),
        .rwe_i(rwe_i), .rwa_i(rwa_i), .rwd_i(rwd_i), .stall_o(stall_o),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
        .misalign_o(misalign_o), .buserr_o(buserr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [RW-1:0] wa;
        logic [DW-1:0] wd;
        logic          mis;
        logic          berr;
    } wb_t;

    wb_t        expq[$];
    wb_t        ce;
    int         total = 0;
    int         bad = 0;
    int         stall_cnt;
    logic [3:0] seen_be;
    logic [31:0] seen_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_aligned(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd3) return 1'b0;
        return (a % (32'd1 << sz)) == 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] rdata, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
        longint unsigned r, v, m, nbytes;
        r = rdata;
        nbytes = 64'd1 << sz;
        v = r >> (8 * (a % 4));
        m = (64'd1 << (8 * nbytes)) - 1;
        v = v & m;
        if (!uns && v >= (m + 1) / 2) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic [3:0] be_model(input logic [31:0] a, input logic [1:0] sz);
        int unsigned nbytes = 1 << sz;
        logic [3:0] b = '0;
        for (int i = 0; i < 4; i++)
            if (i >= int'(a % 4) && i < int'(a % 4) + int'(nbytes)) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] wdata_model(input logic [31:0] sd, input logic [1:0] sz);
        int unsigned nbytes = 1 << sz;
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nbytes) +: 8];
        return w;
    endfunction

    // Compare process: every cycle, WB slot and pulses against the expectation queue.
    always @(negedge clk) begin
        if (wb_valid) begin
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL wb_unexpected: got wb_valid=1 expected no retire at %0t", $time);
            end else begin
                ce = expq.pop_front();
                chk("wb_we", wb_we, ce.we);
                chk("wb_wa", wb_wa, ce.wa);
                if (ce.we) chk("wb_wd", wb_wd, ce.wd);
                chk("misalign_o", misalign_o, ce.mis);
                chk("buserr_o", buserr_o, ce.berr);
            end
        end else begin
            chk("wb_we_bubble", wb_we, 0);
            chk("misalign_bubble", misalign_o, 0);
            chk("buserr_bubble", buserr_o, 0);
        end
    end

    // One instruction, held while stalled; the memory acks after 'waits' BUSY cycles.
    task automatic do_op(input bit valid, input bit rd, input bit wr, input logic [1:0] sz,
                         input bit uns, input logic [31:0] a, input logic [31:0] sd,
                         input bit rwe, input logic [4:0] wa, input logic [31:0] wd,
                         input int waits, input logic [31:0] rdata);
        bit  memop   = valid && (rd || wr) && is_aligned(a, sz);
        bit  mis     = valid && (rd || wr) && !is_aligned(a, sz);
        bit  tout    = memop && (waits >= TO);
        int  s       = !memop ? 0 : (tout ? TO : waits + 1);
        bit  isload  = rd && !wr;
        bit  done    = 1'b0;
        bit  st;
        wb_t e;
        in_valid = valid; mem_rd = rd; mem_wr = wr; mem_size = sz; mem_uns = uns;
        mem_addr = a; st_data = sd; rwe_i = rwe; rwa_i = wa; rwd_i = wd;
        if (valid) begin
            e.we   = (mis || tout) ? 1'b0 : rwe;
            e.wa   = wa;
            e.wd   = (memop && !tout && isload) ? load_val(rdata, a, sz, uns) : wd;
            e.mis  = mis;
            e.berr = tout;
            expq.push_back(e);
        end
        stall_cnt = 0;
        for (int k = 0; k < s + 8; k++) begin
            @(negedge clk);
            chk("dmem_req", dmem_req, memop && k >= 1 && k <= s);
            if (dmem_req) begin
                chk("dmem_addr", dmem_addr, a & ~32'd3);
                chk("dmem_we", dmem_we, wr);
                chk("dmem_be", dmem_be, be_model(a, sz));
                if (wr) chk("dmem_wdata", dmem_wdata, wdata_model(sd, sz));
                seen_be = dmem_be;
                seen_wdata = dmem_wdata;
                dmem_ack = (k == waits + 1);
                dmem_rdata = dmem_ack ? rdata : $urandom;
            end else begin
                dmem_ack = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            #1;
            st = stall_o;
            chk("stall_o", st, k < s);
            if (st) stall_cnt++;
            @(posedge clk); #1;
            if (!st) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL stall_release: got stalled %0d cycles expected %0d", stall_cnt, s);
            in_valid = 1'b0;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            expq.delete();
        end
    endtask

    task automatic idle_op();
        do_op(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0);
    endtask

    task automatic reset_mid_busy();
        in_valid = 1; mem_rd = 1; mem_wr = 0; mem_size = 2'd2; mem_uns = 0;
        mem_addr = 32'h200; rwe_i = 1; rwa_i = 5'd9; rwd_i = 32'h5555_AAAA;
        @(negedge clk); dmem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); dmem_ack = 1'b0;
        chk("rst_pre_req", dmem_req, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_req", dmem_req, 0);
        chk("rst_async_wb_valid", wb_valid, 0);
        chk("rst_async_wb_wa", wb_wa, 0);
        chk("rst_async_wb_wd", wb_wd, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_hold_req", dmem_req, 0);
        rst = 1'b0;
        expq.delete();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; mem_rd = 0; mem_wr = 0; mem_size = 0; mem_uns = 0; mem_addr = 0;
        st_data = 0; rwe_i = 0; rwa_i = 0; rwd_i = 0; dmem_ack = 0; dmem_rdata = 0;
        #7;
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_wb_we", wb_we, 0);
        chk("reset_wb_wd", wb_wd, 0);
        chk("reset_misalign", misalign_o, 0);
        chk("reset_buserr", buserr_o, 0);
        chk("reset_req", dmem_req, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // LW with 3 wait states: ack lands on the timeout cycle and must win.
        do_op(1, 1, 0, 2'd2, 0, 32'h100, 32'h0, 1, 5'd5, 32'h1111, 3, 32'hDEADBEEF);
        chk("lw_stall_cycles", stall_cnt, 4);
        chk("lw_wd", wb_wd, 32'hDEADBEEF);
        chk("lw_we", wb_we, 1);
        do_op(1, 1, 0, 2'd0, 0, 32'h103, 32'h0, 1, 5'd6, 32'h0, 0, 32'h80FF_FF00);
        chk("lb_be", seen_be, 4'b1000);
        chk("lb_wd", wb_wd, 32'hFFFF_FF80);
        do_op(1, 1, 0, 2'd0, 1, 32'h103, 32'h0, 1, 5'd7, 32'h0, 1, 32'h80FF_FF00);
        chk("lbu_wd", wb_wd, 32'h0000_0080);
        do_op(1, 0, 1, 2'd1, 0, 32'h102, 32'hABCD_1234, 1, 5'd8, 32'h77, 0, 32'h0);
        chk("sh_be", seen_be, 4'b1100);
        chk("sh_wdata", seen_wdata, 32'h1234_1234);
        chk("sh_wd", wb_wd, 32'h77);
        do_op(1, 1, 0, 2'd2, 0, 32'h101, 32'h0, 1, 5'd3, 32'h0, 0, 32'h0);
        chk("mis_stall", stall_cnt, 0);
        chk("mis_pulse", misalign_o, 1);
        chk("mis_we", wb_we, 0);
        for (int i = 0; i < 4; i++)
            do_op(1, 0, 0, 2'd0, 0, 32'h0, 32'h0, 1, 5'(i + 1), 32'(100 + i), 0, 32'h0);
        chk("add_wd", wb_wd, 32'd103);
        do_op(1, 1, 0, 2'd2, 0, 32'h300, 32'h0, 1, 5'd4, 32'h0, 100, 32'h0);
        chk("tout_stall", stall_cnt, 4);
        chk("tout_buserr", buserr_o, 1);
        chk("tout_we", wb_we, 0);
        reset_mid_busy();
        do_op(1, 1, 0, 2'd2, 0, 32'h204, 32'h0, 1, 5'd2, 32'h0, 1, 32'hCAFE_F00D);
        chk("post_rst_wd", wb_wd, 32'hCAFE_F00D);

        for (int n = 0; n < 300; n++) begin
            int unsigned kind = $urandom_range(0, 9);
            logic [31:0] a = $urandom;
            if ($urandom_range(0, 9) < 7) a = a & ~32'h7;
            else if ($urandom_range(0, 1) == 1) a = a & ~32'h1;
            do_op($urandom_range(0, 9) != 0,
                  kind inside {[3:5], 9}, kind inside {[6:9]},
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  int'($urandom_range(0, 5)), $urandom);
        end
        idle_op();
        idle_op();
        chk("wb_pending", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
